multdiv_seq: RTL and testbench
==============================

Name: multdiv_seq

Overview:
- Multi-cycle signed 32-bit multiply/divide unit that sits directly upstream of the ALU add/sub path.
- It drives the shared 32-bit add/sub datapath once per cycle: radix-2 Booth for multiply, restoring division for divide.
- It produces the final word, an exception flag and a ready pulse for the writeback stage.
- One operation is in flight at a time.

Parameters:
- WIDTH, 32: operand and result width. Only 32 is supported and verified.
- ITER, 32: iterations per operation. Must equal WIDTH.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_operandA  input  32  multiplicand or dividend; sampled on the start edge.
- data_operandB  input  32  multiplier or divisor; sampled on the start edge.
- ctrl_MULT  input  1  one-cycle start pulse for a multiply.
- ctrl_DIV  input  1  one-cycle start pulse for a divide.
- data_result  output  32  low product word, or the quotient.
- data_exception  output  1  overflow or divide-by-zero flag; valid while data_resultRDY is high.
- data_resultRDY  output  1  one-cycle completion pulse.
- busy  output  1  high while an operation is executing.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0, iteration counter=0. Reset asserted mid-operation aborts the operation with no ready pulse.
- States: IDLE, RUN, DONE.
- Start edge E0: ctrl_MULT or ctrl_DIV sampled high. Operands and op type latch, counter clears, state goes to RUN, busy=1.
- If ctrl_MULT and ctrl_DIV are both high, MULT wins.
- RUN: one iteration per edge, E1..E32. At E32 the state goes to DONE, data_result and data_exception are registered, and data_resultRDY=1, busy=0.
- DONE: lasts one cycle. At E33 data_resultRDY drops and the state returns to IDLE. data_result and data_exception hold until the next start edge.
- Latency: 32 cycles from the start edge to the ready pulse.
- A start pulse in RUN or DONE aborts the current operation and restarts it with the new operands. No ready pulse is issued for the aborted operation.
- Multiply:
  - Booth over a 65-bit {P_hi, P_lo, q-1} register. Each iteration adds 0, +A or -A to P_hi, then arithmetic-shifts right by 1.
  - data_result = P_lo.
  - data_exception=1 iff the 64-bit product does not equal the sign-extension of P_lo.
- Divide:
  - Signed; quotient truncates toward zero.
  - Operate on magnitudes with a 32-bit remainder register. Each iteration shifts left, trial-subtracts |B| and restores on negative.
  - Negate the quotient if sign(A) differs from sign(B). The remainder takes the sign of A.
  - B=0: data_result=0, data_exception=1, with the full 32-cycle latency.
  - A=0x80000000 and B=0xFFFFFFFF: data_result=0x80000000, data_exception=1.
- Widths: all additions are 32-bit two's complement through the add/sub sub-module, and the adder carry-out is discarded. Booth partial sums use a 33-bit guard bit on P_hi.

Optional Feature:
- Macro MULTDIV_REMAINDER_EN.
- When defined: adds output data_remainder (32 bits), reset value 0.
  - Carries the signed remainder, registered at E32 on divides.
  - Forced to 0 on multiplies and on divide-by-zero.
- When undefined: the port and its sign-fix logic are absent. The remainder register stays internal and all other behaviour is identical.

Decomposition:
- Package multdiv_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - OP_MULT/OP_DIV op-type encoding;
  - ITER constant and counter width (6);
  - INT_MIN constant 32'h80000000.
- One sub-module, multdiv_addsub: combinational 32-bit adder with a sub input. Subtract inverts B and injects carry-in. Outputs are sum and signed overflow.
- Control FSM, counter and shift registers stay in multdiv_seq.

Test Plan:
- MULT 6 x 7 -> data_result=0x0000002A, exception=0, rdy pulses exactly 32 cycles after the start edge and lasts one cycle.
- MULT 0x00010000 x 0x00010000 -> data_result=0x00000000, exception=1. MULT 0xFFFFFFFF x 0xFFFFFFFF (-1 x -1) -> 0x00000001, exception=0.
- DIV -7 / 2 -> data_result=0xFFFFFFFD, exception=0. With MULTDIV_REMAINDER_EN, data_remainder=0xFFFFFFFF.
- DIV 5 / 0 -> data_result=0, exception=1 at 32 cycles. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception=1.
- Start MULT 3x3, then pulse DIV 100/7 at cycle 10 -> single rdy pulse 32 cycles after the DIV edge, data_result=0x0000000E.
- Start MULT 9x9, drop reset_n at cycle 15 -> all outputs 0 immediately, no rdy. After release, MULT 2x2 -> 0x00000004 at 32 cycles.

Source files
------------

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared encodings and constants for the sequential multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic [31:0] INT_MIN = 32'h80000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  // Two's-complement magnitude; INT_MIN maps onto itself, read as unsigned 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// multdiv_addsub: combinational add/sub shared by the Booth and restoring-divide steps.
// Subtraction inverts B and injects the carry-in; the carry-out is dropped.
module multdiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] bEff;

  // Effective B operand, sum and signed overflow of the two effective operands.
  always_comb begin
    bEff  = sub_i ? ~b_i : b_i;
    sum_o = a_i + bEff + WIDTH'(sub_i);
    ovf_o = (a_i[WIDTH-1] == bEff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: 32-cycle signed multiply (radix-2 Booth) / divide (restoring) unit.
// Optional feature macro MULTDIV_REMAINDER_EN adds the data_remainder output.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = multdiv_pkg::ITER
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
`ifdef MULTDIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  // opnd_q holds the multiplicand for MULT and |B| for DIV.
  logic [WIDTH-1:0] opnd_q;
  // phi_q/plo_q/qm1_q form the Booth register; plo_q doubles as dividend/quotient.
  logic [WIDTH-1:0] phi_q, plo_q;
  logic             qm1_q;
  logic [WIDTH-1:0] rem_q;
  logic             negQuot_q, divZero_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  logic             startPulse, lastIter, isDiv;
  logic [1:0]       boothBits;
  logic [WIDTH-1:0] addA, addB, addSum;
  logic             addSub, addOvf;
  logic [WIDTH-1:0] multHi, multLo;
  logic             multExc;
  logic [WIDTH-1:0] divShift, divRem, divQuot, quotFix;
  logic             divBorrow, divExc;

  assign startPulse = ctrl_MULT | ctrl_DIV;
  assign lastIter   = (state_q == ST_RUN) && (cnt_q == CNT_W'(ITER - 1));
  assign isDiv      = (op_q == OP_DIV);
  assign boothBits  = {plo_q[0], qm1_q};
  assign divShift   = {rem_q[WIDTH-2:0], plo_q[WIDTH-1]};

  // Operand selection for the shared adder: Booth adds 0/+A/-A, divide trial-subtracts |B|.
  always_comb begin
    addA   = isDiv ? divShift : phi_q;
    addB   = '0;
    addSub = 1'b0;
    if (isDiv) begin
      addB   = opnd_q;
      addSub = 1'b1;
    end else if (boothBits == 2'b01) begin
      addB   = opnd_q;
    end else if (boothBits == 2'b10) begin
      addB   = opnd_q;
      addSub = 1'b1;
    end
  end

  multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i   (addA),
    .b_i   (addB),
    .sub_i (addSub),
    .sum_o (addSum),
    .ovf_o (addOvf)
  );

  // Next iteration values; the Booth guard bit is the true 33-bit sign of the partial sum.
  always_comb begin
    multHi    = {addSum[WIDTH-1] ^ addOvf, addSum[WIDTH-1:1]};
    multLo    = {addSum[0], plo_q[WIDTH-1:1]};
    multExc   = (multHi != {WIDTH{multLo[WIDTH-1]}});
    divBorrow = ~rem_q[WIDTH-1] &
                ((~divShift[WIDTH-1] & opnd_q[WIDTH-1]) |
                 (~(divShift[WIDTH-1] ^ opnd_q[WIDTH-1]) & addSum[WIDTH-1]));
    divRem    = divBorrow ? divShift : addSum;
    divQuot   = {plo_q[WIDTH-2:0], ~divBorrow};
    quotFix   = negQuot_q ? (~divQuot + WIDTH'(1)) : divQuot;
    // A positive 2^31 magnitude only arises from INT_MIN / -1.
    divExc    = divZero_q | (divQuot[WIDTH-1] & ~negQuot_q);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a start pulse restarts from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (startPulse) state_d = ST_RUN;
      ST_RUN: begin
        if (startPulse)    state_d = ST_RUN;
        else if (lastIter) state_d = ST_DONE;
      end
      ST_DONE: state_d = startPulse ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy           = (state_q == ST_RUN);
    data_resultRDY = (state_q == ST_DONE);
  end

  // Datapath: operand latch on start, one Booth or divide step per RUN cycle, result capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      opnd_q    <= '0;
      phi_q     <= '0;
      plo_q     <= '0;
      qm1_q     <= 1'b0;
      rem_q     <= '0;
      negQuot_q <= 1'b0;
      divZero_q <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
    end else if (startPulse) begin
      cnt_q     <= '0;
      phi_q     <= '0;
      qm1_q     <= 1'b0;
      rem_q     <= '0;
      negQuot_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      divZero_q <= (data_operandB == '0);
      if (ctrl_MULT) begin
        op_q   <= OP_MULT;
        opnd_q <= data_operandA;
        plo_q  <= data_operandB;
      end else begin
        op_q   <= OP_DIV;
        opnd_q <= abs32(data_operandB);
        plo_q  <= abs32(data_operandA);
      end
    end else if (state_q == ST_RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (isDiv) begin
        rem_q <= divRem;
        plo_q <= divQuot;
      end else begin
        phi_q <= multHi;
        plo_q <= multLo;
        qm1_q <= plo_q[0];
      end
      if (lastIter) begin
        if (isDiv) begin
          result_q <= divZero_q ? '0 : quotFix;
          exc_q    <= divExc;
        end else begin
          result_q <= multLo;
          exc_q    <= multExc;
        end
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;

`ifdef MULTDIV_REMAINDER_EN
  logic             negRem_q;
  logic [WIDTH-1:0] remOut_q;

  // Remainder sign follows the dividend; captured with the quotient, zero otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      negRem_q <= 1'b0;
      remOut_q <= '0;
    end else if (startPulse) begin
      negRem_q <= data_operandA[WIDTH-1];
    end else if (lastIter) begin
      if (isDiv && !divZero_q) remOut_q <= negRem_q ? (~divRem + WIDTH'(1)) : divRem;
      else                     remOut_q <= '0;
    end
  end

  assign data_remainder = remOut_q;
`endif

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed + random bench for multdiv_seq with an expectation queue.
module tb_multdiv_seq;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
`ifdef MULTDIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  multdiv_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
`ifdef MULTDIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference built on the simulator's signed arithmetic.
  function automatic exp_t refModel(input string name, input bit isMult,
                                    input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint p;
    int     sa, sbv;
    e.name = name;
    e.rem  = '0;
    if (isMult) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      e.res = '0;
      e.exc = 1'b1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      e.res = 32'h80000000;
      e.exc = 1'b1;
    end else begin
      sa    = a;
      sbv   = b;
      e.res = sa / sbv;
      e.rem = sa % sbv;
      e.exc = 1'b0;
    end
    return e;
  endfunction

  task automatic pushExp(input string name, input logic [31:0] res, input logic exc,
                         input logic [31:0] rem);
    exp_t e;
    e.name = name;
    e.res  = res;
    e.exc  = exc;
    e.rem  = rem;
    sb.push_back(e);
  endtask

  // Drive a one-cycle start pulse; returns at the falling edge after the start edge.
  task automatic applyStimulus(input bit doMult, input bit doDiv,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = doMult;
    ctrl_DIV      = doDiv;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
  endtask

  // Wait (bounded) for the ready pulse, then compare against the oldest expectation.
  task automatic awaitResult();
    exp_t e;
    int   cyc = 0;
    checkOutput("busy after start", 32'(busy), 32'd1);
    while (data_resultRDY !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: observed=ready with empty queue expected=pending entry");
      return;
    end
    e = sb.pop_front();
    checkOutput({e.name, " latency"}, 32'(cyc), 32'd32);
    checkOutput({e.name, " result"}, data_result, e.res);
    checkOutput({e.name, " exception"}, 32'(data_exception), 32'(e.exc));
`ifdef MULTDIV_REMAINDER_EN
    checkOutput({e.name, " remainder"}, data_remainder, e.rem);
`endif
    checkOutput({e.name, " busy at ready"}, 32'(busy), 32'd0);
    @(negedge clock);
    checkOutput({e.name, " ready one cycle"}, 32'(data_resultRDY), 32'd0);
  endtask

  initial begin
    int rdyCount;
    logic [31:0] ra, rb;
    exp_t e;

    #1;
    checkOutput("reset result", data_result, 32'd0);
    checkOutput("reset exception", 32'(data_exception), 32'd0);
    checkOutput("reset ready", 32'(data_resultRDY), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    pushExp("mul 6x7", 32'h0000002A, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd6, 32'd7);
    awaitResult();

    pushExp("mul 2^16x2^16", 32'h00000000, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h00010000, 32'h00010000);
    awaitResult();

    pushExp("mul -1x-1", 32'h00000001, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    awaitResult();

    pushExp("div -7/2", 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF);
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    awaitResult();

    pushExp("div 5/0", 32'h00000000, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0);
    awaitResult();

    pushExp("both high mult wins", 32'd18, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'd6, 32'd3);
    awaitResult();

    pushExp("mul INT_MIN x -1", 32'h80000000, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    awaitResult();

    pushExp("mul INT_MIN x INT_MIN", 32'h00000000, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h80000000, 32'h80000000);
    awaitResult();

    for (int i = 0; i < 6; i++) begin
      ra = $urandom();
      rb = $urandom() >> (i * 5);
      if ((i % 2) == 1 && $urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      e = refModel(((i % 2) == 0) ? "rand mul" : "rand div", (i % 2) == 0, ra, rb);
      sb.push_back(e);
      applyStimulus((i % 2) == 0, (i % 2) == 1, ra, rb);
      awaitResult();
    end

    pushExp("abort then div 100/7", 32'h0000000E, 1'b0, 32'd2);
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd3);
    repeat (9) @(negedge clock);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    awaitResult();

    pushExp("div INT_MIN/-1", 32'h80000000, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    awaitResult();

    applyStimulus(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("midop reset result", data_result, 32'd0);
    checkOutput("midop reset exception", 32'(data_exception), 32'd0);
    checkOutput("midop reset ready", 32'(data_resultRDY), 32'd0);
    checkOutput("midop reset busy", 32'(busy), 32'd0);
    rdyCount = 0;
    repeat (3) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdyCount++;
    end
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdyCount++;
    end
    checkOutput("no ready after abort", 32'(rdyCount), 32'd0);

    pushExp("mul 2x2 after reset", 32'h00000004, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd2, 32'd2);
    awaitResult();

    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
